octave_ctrl: RTL
================

Name: octave_ctrl

Overview:
- Front-panel octave controller for the synthesizer. Sits between the raw octave buttons and the synth voice path.
- Synchronizes and debounces the up/down buttons, and arbitrates manual presses against an optional auto-arpeggio tick source.
- Defers each octave change until the current note gap (note_active low), so pitch never steps mid-note.
- Owns and drives the 2-bit oct_switch select consumed by the divider/voice logic.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable samples required before a debounced button level changes; counter width is $clog2(DEBOUNCE_CYCLES+1).
- WRAP, 1: 1 = octave arithmetic wraps modulo 4; 0 = saturate at 0 and 3.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- btn_up  in  1  raw octave-up button, asynchronous to clk
- btn_down  in  1  raw octave-down button, asynchronous to clk
- note_active  in  1  high while a note is sounding; changes are held off while high
- arp_en  in  1  enables auto-arpeggio stepping
- arp_tick  in  1  one-cycle arpeggio step strobe
- oct_switch  out  2  current octave select
- oct_change  out  1  one-cycle pulse in the cycle oct_switch takes a new value
- busy  out  1  high while a change is pending (state != IDLE)

Behaviour:
- Reset (async, nrst low):
  - oct_switch=0, oct_change=0, busy=0, state=IDLE.
  - Sync flops, debounced levels and debounce counters cleared to 0.
  - Pending register cleared; arp direction set to UP.
  - Reset mid-PEND discards the pending request.
- Button path, per button:
  - 2-flop synchronizer, then debounce.
  - Counter increments while the synced level differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A rising edge of the debounced level gives a one-cycle request (up_req / down_req). Falling edges are ignored.
- Request arbitration, evaluated each cycle:
  - up_req and down_req in the same cycle: both discarded.
  - A manual request beats arp_tick in the same cycle; that tick is dropped.
  - arp_tick is honoured only when arp_en=1.
- FSM states: IDLE, PEND, APPLY.
  - IDLE: on any request, load the pending direction and go to PEND.
  - PEND:
    - A new manual request overwrites the pending direction (last press wins); arp_tick is dropped.
    - If note_active=0, compute the target. Target == oct_switch (saturated, WRAP=0): return to IDLE with no pulse. Otherwise go to APPLY.
    - If note_active=1, stay in PEND.
  - APPLY: oct_switch <= target on entry; oct_change=1 for exactly this cycle; next state IDLE. Requests arriving in APPLY are dropped.
- Latency:
  - From request pulse to new oct_switch: 2 cycles when note_active=0.
  - From a raw button edge: 2 sync cycles + DEBOUNCE_CYCLES + 1 cycle to the request pulse.
- Arithmetic:
  - up = +1, down = −1, 2-bit.
  - WRAP=1: 3+1→0, 0−1→3. WRAP=0: clamp to 0..3.
- Arpeggio stepping is ping-pong 0,1,2,3,2,1,0,…
  - Direction flips on reaching 3 (to DOWN) or 0 (to UP), independent of WRAP.
  - A manual change does not alter the arp direction; the next tick continues from the new oct_switch.
  - Deasserting arp_en freezes oct_switch. The direction is retained until reset.

Optional Feature:
- OCT_ARP_EN defined: arpeggio logic is present as described.
- OCT_ARP_EN undefined:
  - arp_en and arp_tick remain ports but are ignored.
  - Direction register and arp arbitration are removed.
  - Only manual requests reach the FSM.

Test Plan:
- DEBOUNCE_CYCLES=4, WRAP=1, note_active=0: press btn_up held 20 cycles → exactly one oct_change; oct_switch 0→1 exactly 2+4+1+2 cycles after the synced edge. Four presses → 1,2,3,0.
- Bounce: btn_up toggles every 2 cycles for 12 cycles, then stays high → single change 0→1. Glitch shorter than 4 cycles → no change.
- Note gating: note_active=1, press down → busy=1, oct_switch stays 0 for 50 cycles. Drop note_active → oct_switch=3 two cycles later, oct_change pulsed once, busy=0.
- WRAP=0, oct_switch=3: press up → no oct_change, oct_switch stays 3, busy returns 0 after one PEND cycle. Simultaneous up+down requests → no state change.
- OCT_ARP_EN defined, arp_en=1, 8 ticks spaced 5 cycles → oct_switch sequence 1,2,3,2,1,0,1,2. Tick coincident with a manual up → only the manual change applied.
- Async reset asserted while in PEND → all outputs 0 immediately; after release, no stale change is applied.

Source files
------------

// File: rtl/octave_ctrl_if.sv
// Front-panel octave controller bus: raw buttons, note gate and arpeggio inputs,
// plus the octave select outputs consumed by the voice path.
interface octave_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       note_active;
  logic       arp_en;
  logic       arp_tick;
  logic [1:0] oct_switch;
  logic       oct_change;
  logic       busy;

  modport master (
    output btn_up, btn_down, note_active, arp_en, arp_tick,
    input  oct_switch, oct_change, busy
  );

  modport slave (
    input  btn_up, btn_down, note_active, arp_en, arp_tick,
    output oct_switch, oct_change, busy
  );
endinterface

// File: rtl/octave_ctrl.sv
// Octave controller: button sync/debounce, request arbitration and note-gap deferred
// octave stepping. Define OCT_ARP_EN to include ping-pong auto-arpeggio stepping.
module octave_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit WRAP            = 1'b1
) (
  input logic          clk,
  input logic          nrst,
  octave_ctrl_if.slave bus
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam int            B_UP     = 0;
  localparam int            B_DN     = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  function automatic logic [1:0] oct_step(input logic [1:0] oct, input logic up);
    logic [1:0] res;
    if (up) begin
      if (WRAP == 1'b1 || oct != 2'd3) res = oct + 2'd1;
      else                             res = oct;
    end else begin
      if (WRAP == 1'b1 || oct != 2'd0) res = oct - 2'd1;
      else                             res = oct;
    end
    return res;
  endfunction

  logic [1:0]    w_btn_raw;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_deb;
  logic [1:0]    r_deb_d;
  logic [1:0]    r_req;
  logic [CW-1:0] r_cnt [2];

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_pdir_up;
  logic          r_parp;
  logic          w_pdir_nxt;
  logic          w_parp_nxt;
  logic          w_eff_up;
  logic          w_eff_arp;
  logic          w_apply;
  logic          w_man_valid;
  logic          w_man_any;
  logic          w_arp_ok;
  logic          w_arp_up;
  logic [1:0]    w_target;
  logic [1:0]    r_oct;
  logic          r_change;
  logic          r_busy;

  assign w_btn_raw   = {bus.btn_down, bus.btn_up};
  assign w_man_valid = r_req[B_UP] ^ r_req[B_DN];
  assign w_man_any   = r_req[B_UP] | r_req[B_DN];

  // Synchronize, debounce and edge-detect both buttons
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sync1  <= 2'b00;
      r_sync2  <= 2'b00;
      r_deb    <= 2'b00;
      r_deb_d  <= 2'b00;
      r_req    <= 2'b00;
      r_cnt[0] <= CNT_ZERO;
      r_cnt[1] <= CNT_ZERO;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      r_req   <= r_deb & ~r_deb_d;
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] != r_deb[b]) begin
          if (r_cnt[b] == CNT_LAST) begin
            r_deb[b] <= ~r_deb[b];
            r_cnt[b] <= CNT_ZERO;
          end else begin
            r_cnt[b] <= r_cnt[b] + CNT_ONE;
          end
        end else begin
          r_cnt[b] <= CNT_ZERO;
        end
      end
    end
  end

`ifdef OCT_ARP_EN
  logic r_arp_up;

  assign w_arp_ok = bus.arp_en & bus.arp_tick & ~w_man_any;

  // Ping-pong direction turns around at the range ends, whatever WRAP says
  always_comb begin
    if (r_oct == 2'd3)      w_arp_up = 1'b0;
    else if (r_oct == 2'd0) w_arp_up = 1'b1;
    else                    w_arp_up = r_arp_up;
  end

  // Remember arpeggio direction only when an arpeggio step is applied
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                      r_arp_up <= 1'b1;
    else if (w_apply && w_eff_arp)  r_arp_up <= w_arp_up;
    else                            r_arp_up <= r_arp_up;
  end
`else
  logic w_unused_arp;

  assign w_arp_ok     = 1'b0;
  assign w_arp_up     = 1'b0;
  assign w_unused_arp = bus.arp_en ^ bus.arp_tick;
`endif

  // A fresh manual press while pending replaces the queued request
  always_comb begin
    if (r_state == ST_PEND && w_man_valid) begin
      w_eff_up  = r_req[B_UP];
      w_eff_arp = 1'b0;
    end else begin
      w_eff_up  = r_pdir_up;
      w_eff_arp = r_parp;
    end
  end

  assign w_target = oct_step(r_oct, w_eff_arp ? w_arp_up : w_eff_up);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_pdir_nxt  = r_pdir_up;
    w_parp_nxt  = r_parp;
    w_apply     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_man_valid) begin
          w_pdir_nxt  = r_req[B_UP];
          w_parp_nxt  = 1'b0;
          w_state_nxt = ST_PEND;
        end else if (w_arp_ok) begin
          w_parp_nxt  = 1'b1;
          w_state_nxt = ST_PEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PEND: begin
        w_pdir_nxt = w_eff_up;
        w_parp_nxt = w_eff_arp;
        if (!bus.note_active) begin
          if (w_target == r_oct) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_APPLY;
            w_apply     = 1'b1;
          end
        end else begin
          w_state_nxt = ST_PEND;
        end
      end
      ST_APPLY: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State, pending request and registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= ST_IDLE;
      r_pdir_up <= 1'b0;
      r_parp    <= 1'b0;
      r_oct     <= 2'd0;
      r_change  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pdir_up <= w_pdir_nxt;
      r_parp    <= w_parp_nxt;
      r_change  <= w_apply;
      r_busy    <= (w_state_nxt != ST_IDLE);
      if (w_apply) r_oct <= w_target;
      else         r_oct <= r_oct;
    end
  end

  assign bus.oct_switch = r_oct;
  assign bus.oct_change = r_change;
  assign bus.busy       = r_busy;

endmodule
